div3_rr_sched: RTL and testbench

- Shares one iterative divide-by-3 engine (repeated subtraction of 3) between N_REQ requesters.
- Round-robin arbitration; valid/ready handshake on each request port; one shared response channel tagged with requester id.
- Sits between lab client blocks and the divide datapath. Replaces per-client combinational dividers with one time-multiplexed unit.

---
 rtl/div3_pkg.sv | 20 ++
 rtl/div3_iter.sv | 48 ++++
 rtl/div3_rr_sched.sv | 133 +++++++++++++
 tb/tb_div3_rr_sched.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div3_pkg.sv
// Shared types and constants for the time-multiplexed divide-by-3 scheduler.
package div3_pkg;

    // Divisor of the iterative engine and the width of its remainder.
    localparam int unsigned DIV_CONST = 3;
    localparam int unsigned REM_W     = 2;

    // Scheduler control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Round-robin successor of idx among n requesters, wrapping to 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/div3_iter.sv
// Iterative divide-by-3 datapath: holds the running remainder and quotient and
// subtracts DIV_CONST once per enabled cycle until the remainder drops below it.
module div3_iter
    import div3_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     din,
    input  logic             step_en,
    output logic             done,
    output logic [W-1:0]     quo,
    output logic [REM_W-1:0] rem
);

    localparam logic [W-1:0] K = W'(DIV_CONST);

    logic [W-1:0] var_q;
    logic [W-1:0] quo_q;
    logic         ge_k;

    // Subtraction is only allowed while var_q >= K, so var_q never underflows.
    assign ge_k = (var_q >= K);

    // Load a fresh operand, or take one subtract-and-count step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            var_q <= '0;
            quo_q <= '0;
        end else if (load) begin
            var_q <= din;
            quo_q <= '0;
        end else if (step_en && ge_k) begin
            var_q <= var_q - K;
            quo_q <= quo_q + W'(1);
        end
    end

    assign done = !ge_k;
    assign quo  = quo_q;
    assign rem  = var_q[REM_W-1:0];

    // Once the engine is done the remainder must already be a legal residue.
    assert property (@(posedge clk) disable iff (!rst_n) done |-> (var_q < K));

endmodule

// File: rtl/div3_rr_sched.sv
// Round-robin scheduler sharing one iterative divide-by-3 engine between
// N_REQ requesters; one tagged response channel with valid/ready backpressure.
module div3_rr_sched
    import div3_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned N_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(N_REQ)-1:0] resp_id,
    output logic [W-1:0]             resp_quo,
    output logic [REM_W-1:0]         resp_rem,
    output logic                     busy
);

    localparam int unsigned IDW = $clog2(N_REQ);

    state_e           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   cur_id;
    logic [IDW-1:0]   next_ptr;

    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   scan_idx;
    logic [W-1:0]     grant_data;
    logic             handshake;

    logic             iter_done;
    logic [W-1:0]     iter_quo;
    logic [REM_W-1:0] iter_rem;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = rr_ptr;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
            scan_idx = (scan_idx == IDW'(N_REQ - 1)) ? '0 : scan_idx + IDW'(1);
        end
    end

    // Select the granted operand; it is only consumed on the handshake cycle.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (grant_id == IDW'(k)) begin
                grant_data = req_data[k*W +: W];
            end
        end
    end

    // Ready only in IDLE and only toward the granted requester.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign handshake = (state == IDLE) && grant_found;
    assign busy      = (state != IDLE);
    assign next_ptr  = IDW'(rr_next(32'(cur_id), N_REQ));

    div3_iter #(
        .W (W)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (handshake),
        .din     (grant_data),
        .step_en (state == CALC),
        .done    (iter_done),
        .quo     (iter_quo),
        .rem     (iter_rem)
    );

    // Control FSM with registered response outputs; the pointer advances only on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_quo   <= '0;
            resp_rem   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (handshake) begin
                        cur_id <= grant_id;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (iter_done) begin
                        resp_valid <= 1'b1;
                        resp_id    <= cur_id;
                        resp_quo   <= iter_quo;
                        resp_rem   <= iter_rem;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= next_ptr;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    assert property (@(posedge clk) disable iff (!rst_n) resp_valid |-> (resp_rem < 2'd3));
    assert property (@(posedge clk) disable iff (!rst_n) resp_valid |-> (state == RESP));

endmodule

// File: tb/tb_div3_rr_sched.sv
// Bench for div3_rr_sched: scenario tasks plus a scoreboard monitor that
// predicts each result at its handshake and checks it at acceptance.
module tb_div3_rr_sched;

    localparam int unsigned W     = 4;
    localparam int unsigned N_REQ = 2;
    localparam int unsigned IDW   = $clog2(N_REQ);

    logic                 clk;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*W-1:0]   req_data;
    logic [N_REQ-1:0]     req_ready;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [W-1:0]         resp_quo;
    logic [1:0]           resp_rem;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   quo;
        logic [1:0]     rem;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    exp_t         mon_got;
    logic [W-1:0] mon_x;

    div3_rr_sched #(
        .W     (W),
        .N_REQ (N_REQ)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_quo   (resp_quo),
        .resp_rem   (resp_rem),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push the model result at each handshake, pop on each accepted response.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (req_ready != '0) begin
                checks++;
                if ((req_ready & (req_ready - 1'b1)) != '0) begin
                    errors++;
                    $display("FAIL ready_onehot: req_ready=%b, required at most one bit", req_ready);
                end
            end
            for (int k = 0; k < int'(N_REQ); k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    mon_x     = req_data[k*W +: W];
                    mon_e.id  = IDW'(k);
                    mon_e.quo = W'(mon_x / 3);
                    mon_e.rem = 2'(mon_x % 3);
                    sb.push_back(mon_e);
                end
            end
            if (resp_valid && resp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: response id=%0d quo=%0d rem=%0d with no request",
                             resp_id, resp_quo, resp_rem);
                end else begin
                    mon_e   = sb.pop_front();
                    mon_got = '{id: resp_id, quo: resp_quo, rem: resp_rem};
                    if (mon_got !== mon_e) begin
                        errors++;
                        $display("FAIL sb_result: got id=%0d quo=%0d rem=%0d, required id=%0d quo=%0d rem=%0d",
                                 resp_id, resp_quo, resp_rem, mon_e.id, mon_e.quo, mon_e.rem);
                    end
                end
            end
        end
    end

    // Present operand x on requester k until granted; returns the handshake cycle.
    task automatic send(input int k, input logic [W-1:0] x, output int hs);
        req_data[k*W +: W] = x;
        req_valid[k]       = 1'b1;
        hs = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                hs = cyc;
                break;
            end
        end
        checks++;
        if (hs < 0) begin
            errors++;
            $display("FAIL grant_timeout: requester %0d got no grant, required one within 50 cycles", k);
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
    endtask

    // Wait for a response with resp_ready high; returns its first cycle and fields.
    task automatic wait_resp(output int rv, output logic [IDW-1:0] id, output logic [W-1:0] q,
                             output logic [1:0] r);
        rv = -1;
        id = '0;
        q  = '0;
        r  = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                rv = cyc;
                id = resp_id;
                q  = resp_quo;
                r  = resp_rem;
                break;
            end
        end
        checks++;
        if (rv < 0) begin
            errors++;
            $display("FAIL resp_timeout: resp_valid never rose, required within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({resp_valid, resp_id, resp_quo, resp_rem, busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b id=%0d quo=%0d rem=%0d busy=%b ready=%b, required all 0",
                     resp_valid, resp_id, resp_quo, resp_rem, busy, req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid=%b, required 0/0", busy, resp_valid);
        end
    endtask

    task automatic test_single();
        int hs, rv;
        logic [IDW-1:0] id;
        logic [W-1:0] q;
        logic [1:0] r;
        send(0, 4'd9, hs);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: busy=%b, required 1", busy);
        end
        wait_resp(rv, id, q, r);
        checks++;
        if (rv - hs != 5 || id !== 1'b0 || q !== 4'd3 || r !== 2'd0) begin
            errors++;
            $display("FAIL single: lat=%0d id=%0d quo=%0d rem=%0d, required 5/0/3/0", rv - hs, id, q, r);
        end
    endtask

    task automatic test_boundary();
        int bx[4] = '{0, 2, 3, 15};
        int bq[4] = '{0, 0, 1, 5};
        int br[4] = '{0, 2, 0, 0};
        int bl[4] = '{2, 2, 3, 7};
        int hs, rv;
        logic [IDW-1:0] id;
        logic [W-1:0] q;
        logic [1:0] r;
        for (int i = 0; i < 4; i++) begin
            send(0, W'(bx[i]), hs);
            wait_resp(rv, id, q, r);
            checks++;
            if (rv - hs != bl[i] || q !== W'(bq[i]) || r !== 2'(br[i])) begin
                errors++;
                $display("FAIL boundary x=%0d: lat=%0d quo=%0d rem=%0d, required %0d/%0d/%0d",
                         bx[i], rv - hs, q, r, bl[i], bq[i], br[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int grants[4];
        int ng = 0;
        int nr = 0;
        int exp_order[4] = '{0, 1, 0, 1};
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_data   = {4'd14, 4'd7};
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        for (int c = 0; c < 200 && nr < 4; c++) begin
            @(negedge clk);
            if (req_ready != '0 && ng < 4) begin
                grants[ng] = req_ready[1] ? 1 : 0;
                ng++;
            end
            if (resp_valid && resp_ready) begin
                checks++;
                if ((resp_id == 1'b0 && (resp_quo !== 4'd2 || resp_rem !== 2'd1)) ||
                    (resp_id == 1'b1 && (resp_quo !== 4'd4 || resp_rem !== 2'd2))) begin
                    errors++;
                    $display("FAIL b2b_result: id=%0d quo=%0d rem=%0d, required (0,2,1) or (1,4,2)",
                             resp_id, resp_quo, resp_rem);
                end
                nr++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        checks++;
        if (ng != 4 || nr != 4) begin
            errors++;
            $display("FAIL b2b_count: grants=%0d responses=%0d, required 4/4", ng, nr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grants[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: grant=%0d, required %0d", i, grants[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int hs, rv;
        logic [IDW-1:0] id;
        logic [W-1:0] q;
        logic [1:0] r;
        resp_ready = 1'b0;
        send(1, 4'd10, hs);
        rv = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                rv = cyc;
                break;
            end
        end
        checks++;
        if (rv - hs != 5) begin
            errors++;
            $display("FAIL bp_latency: lat=%0d, required 5", rv - hs);
        end
        @(posedge clk);
        #1;
        req_data[0 +: W] = 4'd5;
        req_valid[0]     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_quo !== 4'd3 || resp_rem !== 2'd1 ||
                busy !== 1'b1 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b id=%0d quo=%0d rem=%0d busy=%b ready=%b, required 1/1/3/1/1/00",
                         c, resp_valid, resp_id, resp_quo, resp_rem, busy, req_ready);
            end
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept_cycle: ready=%b valid=%b, required 00/1", req_ready, resp_valid);
        end
        send(0, 4'd5, hs);
        wait_resp(rv, id, q, r);
        checks++;
        if (id !== 1'b0 || q !== 4'd1 || r !== 2'd2) begin
            errors++;
            $display("FAIL bp_next: id=%0d quo=%0d rem=%0d, required 0/1/2", id, q, r);
        end
    endtask

    task automatic test_reset_mid_calc();
        int hs, rv;
        logic [IDW-1:0] id;
        logic [W-1:0] q;
        logic [1:0] r;
        send(0, 4'd15, hs);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({resp_valid, resp_id, resp_quo, resp_rem, busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b id=%0d quo=%0d rem=%0d busy=%b ready=%b, required all 0",
                     resp_valid, resp_id, resp_quo, resp_rem, busy, req_ready);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_data  = {4'd8, 4'd4};
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midreset_ptr: req_ready=%b, required 01", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_resp(rv, id, q, r);
        checks++;
        if (id !== 1'b0 || q !== 4'd1 || r !== 2'd1) begin
            errors++;
            $display("FAIL midreset_x4: id=%0d quo=%0d rem=%0d, required 0/1/1", id, q, r);
        end
        send(1, 4'd8, hs);
        wait_resp(rv, id, q, r);
        checks++;
        if (id !== 1'b1 || q !== 4'd2 || r !== 2'd2) begin
            errors++;
            $display("FAIL midreset_x8: id=%0d quo=%0d rem=%0d, required 1/2/2", id, q, r);
        end
    endtask

    task automatic test_sweep();
        int hs, rv;
        logic [IDW-1:0] id;
        logic [W-1:0] q;
        logic [1:0] r;
        for (int x = 0; x < 16; x++) begin
            send(x % 2, W'(x), hs);
            wait_resp(rv, id, q, r);
            checks++;
            if (id !== IDW'(x % 2) || q !== W'(x / 3) || r !== 2'(x % 3) || rv - hs != 2 + x / 3) begin
                errors++;
                $display("FAIL sweep x=%0d: id=%0d quo=%0d rem=%0d lat=%0d, required %0d/%0d/%0d/%0d",
                         x, id, q, r, rv - hs, x % 2, x / 3, x % 3, 2 + x / 3);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b1;
        test_reset();
        test_single();
        test_boundary();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_calc();
        test_sweep();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required completion within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
